seq_mul_add_8bit: RTL and testbench
===================================

Name: seq_mul_add_8bit

Overview:
Sequential radix-2 shift-add unit that computes R = A*B + C, unsigned. It is the inverse companion of the 8-bit non-restoring divider: it rebuilds dividend = quotient*divisor + remainder. It serves as a standalone multiplier and as a built-in checker for divider results. It uses the same start/busy handshake style as the divider, with a fixed latency independent of the operand values.

Parameters:
WIDTH, 8, operand width N of a, b, c; the result is 2N bits; the iteration count equals N.
CNT_W, 4, width of the iteration counter; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  rising-edge clock
reset  input  1  reset, asynchronous, active-high
start  input  1  request; sampled only while in IDLE
a  input  WIDTH  multiplicand, unsigned (e.g. quotient)
b  input  WIDTH  multiplier, unsigned (e.g. divisor)
c  input  WIDTH  addend, unsigned (e.g. remainder)
result  output  2*WIDTH  registered A*B+C; held until the next completion
busy  output  1  high in every state except IDLE (decoded from the state register)
done  output  1  registered one-cycle pulse when result updates
wide_flag  output  1  registered; 1 if result[2N-1:N] != 0, i.e. the result does not fit in N bits

Behaviour:
- Reset (asynchronous, any state) forces:
  - state to IDLE;
  - result, done, wide_flag, count and all internal registers to 0;
  - busy to 0.
- A reset during an operation aborts it. Nothing is written. No done pulse is produced.
- FSM states: IDLE -> MULT -> FINISH -> IDLE. Unused encodings go to IDLE.
- Edge E0 (IDLE with start=1):
  - latch mcand = {N'b0, a} (2N bits), mplier = b and acc = {N'b0, c};
  - count <= WIDTH;
  - go to MULT.
- The inputs a, b and c are don't-care after E0.
- IDLE with start=0: hold. done is 0 in every cycle except the completion cycle.
- MULT, each edge while count > 0:
  - if mplier[0] is 1, acc <= acc + mcand (2N-bit add; cannot overflow because (2^N-1)^2 + (2^N-1) < 2^2N);
  - mcand <= mcand << 1;
  - mplier <= mplier >> 1;
  - count <= count - 1.
- When count == 1, that edge is the last iteration and the next state is FINISH. count == 0 in MULT (safety case) also goes to FINISH.
- FINISH edge E(N+1):
  - result <= acc;
  - wide_flag <= |acc[2N-1:N];
  - done <= 1 for exactly one cycle;
  - go to IDLE.
- Latency: result and done are visible after edge E(N+1), which is E9 for N=8. busy is high from after E0 until E9, i.e. N+1 cycles. The latency is fixed and there is no early exit for zero operands.
- start while busy is ignored, with no queueing and no effect on the operation in progress.
- start held high continuously:
  - the unit returns to IDLE after FINISH and accepts a new operation on the following edge;
  - throughput is one operation per N+2 cycles;
  - done pulses once per operation.
- Zero operands (a=0 or b=0) give result = c. With all inputs 0, result = 0 and done still pulses.
- result and wide_flag are not modified outside FINISH.

Test Plan:
- Reset, then a=13, b=11, c=7 with a 1-cycle start -> busy high for 9 cycles; after E9 result=150, wide_flag=0, done=1 for exactly one cycle.
- Divider round trip: a=28, b=7, c=4 -> result=200. Also a=255, b=1, c=0 -> result=255, wide_flag=0.
- Max operands: a=255, b=255, c=255 -> result=65280 (0xFF00), wide_flag=1.
- Zero cases:
  - a=0, b=200, c=9 -> result=9;
  - a=0, b=0, c=0 -> result=0, done pulses at E9.
- start pulsed again at E3 with a=1, b=1, c=1 during the a=13 run -> ignored; result=150, and only one done pulse.
- Reset asserted at E5 mid-run -> busy=0, result=0, no done pulse. start held high through two operations (a=2, b=3, c=0, then a=4, b=5, c=1) -> result=6 then 21, with two done pulses 10 cycles apart.

Source files
------------

// File: rtl/seq_mul_add_8bit_if.sv
// Start/busy handshake bundle for the shift-add multiply-accumulate unit.
// The master drives the operands and start; the slave returns result and status.
interface seq_mul_add_8bit_if #(
   parameter int WIDTH = 8
);
   logic                 start;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic [WIDTH-1:0]     c;
   logic [2*WIDTH-1:0]   result;
   logic                 busy;
   logic                 done;
   logic                 wide_flag;

   modport master (
      output start, a, b, c,
      input  result, busy, done, wide_flag
   );

   modport slave (
      input  start, a, b, c,
      output result, busy, done, wide_flag
   );
endinterface

// File: rtl/seq_mul_add_8bit.sv
// Sequential radix-2 shift-add unit computing result = a*b + c, unsigned.
// Fixed latency of WIDTH+1 cycles from the accepting edge to done.
module seq_mul_add_8bit #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   seq_mul_add_8bit_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MULT   = 2'd1,
      FINISH = 2'd2
   } state_t;

   localparam int W2 = 2 * WIDTH;

   state_t             state_q;
   state_t             state_d;
   logic [W2-1:0]      mcand_q;
   logic [WIDTH-1:0]   mplier_q;
   logic [W2-1:0]      acc_q;
   logic [CNT_W-1:0]   count_q;
   logic [W2-1:0]      result_q;
   logic               done_q;
   logic               wide_q;

   // State register; reset aborts any operation in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state decode; the unused encoding falls back to IDLE.
   always_comb begin
      state_d = IDLE;
      unique case (state_q)
         IDLE:    state_d = bus.start ? MULT : IDLE;
         MULT:    state_d = (count_q <= CNT_W'(1)) ? FINISH : MULT;
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath: latch operands, shift-add once per MULT cycle, publish on FINISH.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         count_q  <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
         wide_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (bus.start) begin
                  mcand_q  <= {{WIDTH{1'b0}}, bus.a};
                  mplier_q <= bus.b;
                  acc_q    <= {{WIDTH{1'b0}}, bus.c};
                  count_q  <= CNT_W'(WIDTH);
               end
            end
            MULT: begin
               if (count_q != '0) begin
                  if (mplier_q[0]) acc_q <= acc_q + mcand_q;
                  mcand_q  <= mcand_q << 1;
                  mplier_q <= mplier_q >> 1;
                  count_q  <= count_q - CNT_W'(1);
               end
            end
            FINISH: begin
               result_q <= acc_q;
               wide_q   <= |acc_q[W2-1:WIDTH];
               done_q   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.result    = result_q;
   assign bus.done      = done_q;
   assign bus.wide_flag = wide_q;
   assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_seq_mul_add_8bit.sv
// Self-checking bench for seq_mul_add_8bit.
// Expected values come from plain a*b+c arithmetic and the fixed latency.
module tb_seq_mul_add_8bit;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;

   seq_mul_add_8bit_if #(.WIDTH(8)) bus ();

   seq_mul_add_8bit #(.WIDTH(8), .CNT_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] ref_mac(input logic [7:0] a, b, c);
      int unsigned r;
      r = int'(a) * int'(b) + int'(c);
      return r[15:0];
   endfunction

   // Runs one operation; optional poke of start or reset at window index.
   task automatic do_op(
      input  logic [7:0] a_i, b_i, c_i,
      input  int         poke_at,
      input  int         rst_at,
      output logic [15:0] res,
      output logic        wf,
      output int          busy_cyc,
      output int          dones,
      output int          done_idx
   );
      res      = 'x;
      wf       = 1'bx;
      busy_cyc = 0;
      dones    = 0;
      done_idx = -1;
      @(negedge clk);
      bus.start = 1'b1;
      bus.a = a_i;
      bus.b = b_i;
      bus.c = c_i;
      @(negedge clk);
      for (int i = 0; i < 15; i++) begin
         if (i == 0) begin
            bus.start = 1'b0;
            bus.a = 8'($urandom);
            bus.b = 8'($urandom);
            bus.c = 8'($urandom);
         end
         if (i == poke_at) begin
            bus.start = 1'b1;
            bus.a = 8'd1;
            bus.b = 8'd1;
            bus.c = 8'd1;
         end
         if (i == poke_at + 1) bus.start = 1'b0;
         if (i == rst_at) reset = 1'b1;
         if (i == rst_at + 1) reset = 1'b0;
         #1;
         if (bus.busy) busy_cyc++;
         if (bus.done) begin
            dones++;
            done_idx = i;
            res = bus.result;
            wf = bus.wide_flag;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1;
      #1;
      n_cmp++;
      if (bus.busy !== 1'b0) begin
         n_err++;
         $display("FAIL reset_busy got %b want 0", bus.busy);
      end
      n_cmp++;
      if (bus.done !== 1'b0) begin
         n_err++;
         $display("FAIL reset_done got %b want 0", bus.done);
      end
      n_cmp++;
      if (bus.result !== 16'd0) begin
         n_err++;
         $display("FAIL reset_result got %0d want 0", bus.result);
      end
      n_cmp++;
      if (bus.wide_flag !== 1'b0) begin
         n_err++;
         $display("FAIL reset_wide got %b want 0", bus.wide_flag);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_basic();
      logic [15:0] r;
      logic        w;
      int          bc, dn, di;
      do_op(8'd13, 8'd11, 8'd7, -10, -10, r, w, bc, dn, di);
      n_cmp++;
      if (bc !== 9) begin
         n_err++;
         $display("FAIL basic_busy got %0d want 9", bc);
      end
      n_cmp++;
      if (dn !== 1 || di !== 9) begin
         n_err++;
         $display("FAIL basic_done got n=%0d at %0d want 1 at 9", dn, di);
      end
      n_cmp++;
      if (r !== 16'd150 || w !== 1'b0) begin
         n_err++;
         $display("FAIL basic_result got %0d/%b want 150/0", r, w);
      end
      n_cmp++;
      if (bus.result !== 16'd150) begin
         n_err++;
         $display("FAIL basic_hold got %0d want 150", bus.result);
      end
   endtask

   task automatic test_directed();
      logic [7:0]  va[5];
      logic [7:0]  vb[5];
      logic [7:0]  vc[5];
      logic [15:0] r;
      logic        w;
      int          bc, dn, di;
      va = '{8'd28, 8'd255, 8'd255, 8'd0, 8'd0};
      vb = '{8'd7, 8'd1, 8'd255, 8'd200, 8'd0};
      vc = '{8'd4, 8'd0, 8'd255, 8'd9, 8'd0};
      for (int k = 0; k < 5; k++) begin
         do_op(va[k], vb[k], vc[k], -10, -10, r, w, bc, dn, di);
         n_cmp++;
         if (dn !== 1 || di !== 9 || bc !== 9) begin
            n_err++;
            $display("FAIL dir%0d_timing got n=%0d at %0d busy %0d want 1 at 9 busy 9",
                     k, dn, di, bc);
         end
         n_cmp++;
         if (r !== ref_mac(va[k], vb[k], vc[k]) ||
             w !== (ref_mac(va[k], vb[k], vc[k]) > 16'd255)) begin
            n_err++;
            $display("FAIL dir%0d_result got %0d/%b want %0d", k, r, w,
                     ref_mac(va[k], vb[k], vc[k]));
         end
      end
   endtask

   task automatic test_start_ignored();
      logic [15:0] r;
      logic        w;
      int          bc, dn, di;
      do_op(8'd13, 8'd11, 8'd7, 2, -10, r, w, bc, dn, di);
      n_cmp++;
      if (dn !== 1 || di !== 9) begin
         n_err++;
         $display("FAIL ignore_done got n=%0d at %0d want 1 at 9", dn, di);
      end
      n_cmp++;
      if (r !== 16'd150) begin
         n_err++;
         $display("FAIL ignore_result got %0d want 150", r);
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] r;
      logic        w;
      int          bc, dn, di;
      do_op(8'd200, 8'd100, 8'd50, -10, 4, r, w, bc, dn, di);
      n_cmp++;
      if (dn !== 0) begin
         n_err++;
         $display("FAIL abort_done got %0d pulses want 0", dn);
      end
      n_cmp++;
      if (bc !== 4 || bus.busy !== 1'b0) begin
         n_err++;
         $display("FAIL abort_busy got %0d cycles/%b want 4/0", bc, bus.busy);
      end
      n_cmp++;
      if (bus.result !== 16'd0 || bus.wide_flag !== 1'b0) begin
         n_err++;
         $display("FAIL abort_result got %0d/%b want 0/0",
                  bus.result, bus.wide_flag);
      end
   endtask

   task automatic test_back_to_back();
      int          idx[$];
      logic [15:0] res[$];
      @(negedge clk);
      bus.start = 1'b1;
      bus.a = 8'd2;
      bus.b = 8'd3;
      bus.c = 8'd0;
      @(negedge clk);
      for (int i = 0; i < 30; i++) begin
         if (i == 0) begin
            bus.a = 8'd4;
            bus.b = 8'd5;
            bus.c = 8'd1;
         end
         if (i == 10) bus.start = 1'b0;
         #1;
         if (bus.done) begin
            idx.push_back(i);
            res.push_back(bus.result);
         end
         @(negedge clk);
      end
      n_cmp++;
      if (idx.size() !== 2) begin
         n_err++;
         $display("FAIL b2b_count got %0d want 2", idx.size());
      end else begin
         n_cmp++;
         if (idx[1] - idx[0] !== 10 || idx[0] !== 9) begin
            n_err++;
            $display("FAIL b2b_spacing got %0d,%0d want 9,19", idx[0], idx[1]);
         end
         n_cmp++;
         if (res[0] !== 16'd6 || res[1] !== 16'd21) begin
            n_err++;
            $display("FAIL b2b_result got %0d,%0d want 6,21", res[0], res[1]);
         end
      end
   endtask

   task automatic test_random();
      logic [7:0]  ra, rb, rc;
      logic [15:0] r, e;
      logic        w;
      int          bc, dn, di;
      for (int k = 0; k < 25; k++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rc = 8'($urandom);
         e  = ref_mac(ra, rb, rc);
         do_op(ra, rb, rc, -10, -10, r, w, bc, dn, di);
         n_cmp++;
         if (dn !== 1 || di !== 9 || r !== e || w !== (e > 16'd255)) begin
            n_err++;
            $display("FAIL rand%0d %0d*%0d+%0d got %0d/%b n=%0d at %0d want %0d/%b",
                     k, ra, rb, rc, r, w, dn, di, e, (e > 16'd255));
         end
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b1;
      bus.start = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.c = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      test_reset();
      test_basic();
      test_directed();
      test_start_ignored();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
